pc_next_sequencer: RTL and testbench

//   Owns the program counter register and picks the next PC. Sources: sequential

---
 rtl/pc_next_sequencer.sv | 145 ++++++++++++++
 tb/tb_pc_next_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_next_sequencer.sv
// -----------------------------------------------------------------------------
// pc_next_sequencer
//   Holds the program counter and chooses the next PC. Sources, highest
//   priority first: exception vector, taken branch, jump, latched (pending)
//   redirect target, sequential increment. A stall freezes the PC. A branch or
//   jump that arrives during a stall is latched and applied when the stall
//   releases. Exceptions are never stalled.
//
// Parameters
//   WIDTH       PC / target width in bits
//   RESET_PC    pc_o value after reset
//   EXC_VECTOR  exception entry address
//   INC         sequential increment
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   stall_i       hold PC this cycle
//   br_taken_i    branch resolved taken
//   br_target_i   branch target
//   jmp_i         unconditional jump request
//   jmp_target_i  jump target
//   exc_i         exception request
//   pc_o          current PC (registered)
//   pc_inc_o      pc_o + INC (combinational, wraps)
//   redirect_o    pc_o was loaded from a non-sequential source at the last edge
//   pending_o     a redirect is latched, waiting for stall release (FSM in HOLD)
//
// Request semantics: br_taken_i, jmp_i and exc_i are level requests sampled on
// every rising edge; there is no ready/acknowledge. A request sampled while
// stalled is latched (br/jmp) or applied at once (exc).
// -----------------------------------------------------------------------------
module pc_next_sequencer #(
  parameter int unsigned            WIDTH      = 32,
  parameter logic [WIDTH-1:0]       RESET_PC   = '0,
  parameter logic [WIDTH-1:0]       EXC_VECTOR = WIDTH'(32'h0000_0180),
  parameter int unsigned            INC        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             br_taken_i,
  input  logic [WIDTH-1:0] br_target_i,
  input  logic             jmp_i,
  input  logic [WIDTH-1:0] jmp_target_i,
  input  logic             exc_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_inc_o,
  output logic             redirect_o,
  output logic             pending_o
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_pend_tgt;
  logic             r_redirect;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [WIDTH-1:0] w_pend_nxt;
  logic             w_redirect_nxt;
  logic             w_bj_req;
  logic [WIDTH-1:0] w_bj_tgt;
  logic [WIDTH-1:0] w_pc_inc;

  assign w_pc_inc = r_pc + INC_W;

  // Branch beats jump when both are asserted in the same cycle.
  assign w_bj_req = br_taken_i | jmp_i;
  assign w_bj_tgt = br_taken_i ? br_target_i : jmp_target_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RUN;
      r_pc       <= RESET_PC;
      r_pend_tgt <= '0;
      r_redirect <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_pend_tgt <= w_pend_nxt;
      r_redirect <= w_redirect_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_pend_nxt     = r_pend_tgt;
    w_redirect_nxt = 1'b0;

    if (exc_i) begin
      // Exceptions ignore stall and discard any latched redirect.
      w_pc_nxt       = EXC_VECTOR;
      w_pend_nxt     = '0;
      w_state_nxt    = RUN;
      w_redirect_nxt = 1'b1;
    end else begin
      unique case (r_state)
        RUN: begin
          if (!stall_i) begin
            if (w_bj_req) begin
              w_pc_nxt       = w_bj_tgt;
              w_redirect_nxt = 1'b1;
            end else begin
              w_pc_nxt = w_pc_inc;
            end
          end else if (w_bj_req) begin
            w_pend_nxt  = w_bj_tgt;
            w_state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (stall_i) begin
            // Newest request replaces the latched target.
            if (w_bj_req) begin
              w_pend_nxt = w_bj_tgt;
            end
          end else begin
            w_pc_nxt       = w_bj_req ? w_bj_tgt : r_pend_tgt;
            w_redirect_nxt = 1'b1;
            w_pend_nxt     = '0;
            w_state_nxt    = RUN;
          end
        end
        default: begin
          w_state_nxt = RUN;
        end
      endcase
    end
  end

  assign pc_o       = r_pc;
  assign pc_inc_o   = w_pc_inc;
  assign redirect_o = r_redirect;
  assign pending_o  = (r_state == HOLD);

endmodule

// File: tb/tb_pc_next_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_next_sequencer
//   Drives a 32-bit and an 8-bit instance of pc_next_sequencer with the same
//   stimulus. A behavioural model of the PC (pending flag + target, plain
//   arithmetic) is compared against both instances on every falling edge, and
//   directed scenarios pin literal expected values.
// -----------------------------------------------------------------------------
module tb_pc_next_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus ----------------
  logic        stall_i    = 1'b0;
  logic        br_taken_i = 1'b0;
  logic [31:0] br_target_i = '0;
  logic        jmp_i      = 1'b0;
  logic [31:0] jmp_target_i = '0;
  logic        exc_i      = 1'b0;

  logic [31:0] pc32, pc_inc32;
  logic        red32, pend32;
  logic [7:0]  pc8, pc_inc8;
  logic        red8, pend8;

  pc_next_sequencer #(.WIDTH(32)) u_dut32 (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .br_taken_i   (br_taken_i),
    .br_target_i  (br_target_i),
    .jmp_i        (jmp_i),
    .jmp_target_i (jmp_target_i),
    .exc_i        (exc_i),
    .pc_o         (pc32),
    .pc_inc_o     (pc_inc32),
    .redirect_o   (red32),
    .pending_o    (pend32)
  );

  pc_next_sequencer #(.WIDTH(8)) u_dut8 (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .br_taken_i   (br_taken_i),
    .br_target_i  (br_target_i[7:0]),
    .jmp_i        (jmp_i),
    .jmp_target_i (jmp_target_i[7:0]),
    .exc_i        (exc_i),
    .pc_o         (pc8),
    .pc_inc_o     (pc_inc8),
    .redirect_o   (red8),
    .pending_o    (pend8)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Index 0 models the 32-bit instance, index 1 the 8-bit one.
  localparam logic [31:0] MASK [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
  logic [31:0] m_pc  [2];
  logic [31:0] m_pt  [2];
  bit          m_pv  [2];
  bit          m_rd  [2];

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_pc[k] = 32'h0;
        m_pt[k] = 32'h0;
        m_pv[k] = 1'b0;
        m_rd[k] = 1'b0;
      end else if (exc_i) begin
        m_pc[k] = 32'h180 & MASK[k];
        m_pv[k] = 1'b0;
        m_rd[k] = 1'b1;
      end else if (stall_i) begin
        m_rd[k] = 1'b0;
        if (br_taken_i || jmp_i) begin
          m_pv[k] = 1'b1;
          m_pt[k] = (br_taken_i ? br_target_i : jmp_target_i) & MASK[k];
        end
      end else begin
        if (br_taken_i || jmp_i) begin
          m_pc[k] = (br_taken_i ? br_target_i : jmp_target_i) & MASK[k];
          m_rd[k] = 1'b1;
        end else if (m_pv[k]) begin
          m_pc[k] = m_pt[k];
          m_rd[k] = 1'b1;
        end else begin
          m_pc[k] = (m_pc[k] + 32'd4) & MASK[k];
          m_rd[k] = 1'b0;
        end
        m_pv[k] = 1'b0;
      end
    end
  end

  // Per-cycle compare, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc32",      pc32,            m_pc[0]);
      check("pc_inc32",  pc_inc32,        m_pc[0] + 32'd4);
      check("redirect32", {31'b0, red32}, {31'b0, m_rd[0]});
      check("pending32", {31'b0, pend32}, {31'b0, m_pv[0]});
      check("pc8",       {24'b0, pc8},    m_pc[1]);
      check("pc_inc8",   {24'b0, pc_inc8}, (m_pc[1] + 32'd4) & MASK[1]);
      check("redirect8", {31'b0, red8},   {31'b0, m_rd[1]});
      check("pending8",  {31'b0, pend8},  {31'b0, m_pv[1]});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_req();
    br_taken_i = 1'b0;
    jmp_i      = 1'b0;
    exc_i      = 1'b0;
  endtask

  // ---------------- directed + random ----------------
  initial begin
    // Reset held across two edges.
    step();
    step();
    rst = 1'b0;
    check("rst_pc",       pc32,            32'h0);
    check("rst_redirect", {31'b0, red32},  32'h0);
    check("rst_pending",  {31'b0, pend32}, 32'h0);
    chk_en = 1'b1;

    // Free-running increment.
    step(); check("seq_pc_1", pc32, 32'h4); check("seq_red_1", {31'b0, red32}, 32'h0);
    step(); check("seq_pc_2", pc32, 32'h8);
    step(); check("seq_pc_3", pc32, 32'hC); check("seq_inc_3", pc_inc32, 32'h10);

    // Taken branch.
    br_taken_i = 1'b1; br_target_i = 32'h40;
    step(); check("br_pc", pc32, 32'h40); check("br_red", {31'b0, red32}, 32'h1);
    br_taken_i = 1'b0;
    step(); check("br_pc_next", pc32, 32'h44); check("br_red_next", {31'b0, red32}, 32'h0);

    // Move to 0x10, then a jump during a three-cycle stall.
    jmp_i = 1'b1; jmp_target_i = 32'h10;
    step(); check("jmp_pc", pc32, 32'h10);
    stall_i = 1'b1; jmp_target_i = 32'h100;
    step(); check("hold_pc_1", pc32, 32'h10); check("hold_pend_1", {31'b0, pend32}, 32'h1);
    jmp_i = 1'b0;
    step(); check("hold_pc_2", pc32, 32'h10); check("hold_red_2", {31'b0, red32}, 32'h0);
    step(); check("hold_pc_3", pc32, 32'h10);
    stall_i = 1'b0;
    step(); check("release_pc", pc32, 32'h100); check("release_red", {31'b0, red32}, 32'h1);
    check("release_pend", {31'b0, pend32}, 32'h0);

    // Newer branch overwrites a pending jump.
    stall_i = 1'b1; jmp_i = 1'b1; jmp_target_i = 32'h100;
    step(); jmp_i = 1'b0; br_taken_i = 1'b1; br_target_i = 32'h200;
    step(); br_taken_i = 1'b0;
    step(); stall_i = 1'b0;
    step(); check("overwrite_pc", pc32, 32'h200); check("overwrite_red", {31'b0, red32}, 32'h1);

    // Exception beats a stalled jump.
    stall_i = 1'b1; exc_i = 1'b1; jmp_i = 1'b1; jmp_target_i = 32'h300;
    step(); check("exc_pc", pc32, 32'h180); check("exc_pend", {31'b0, pend32}, 32'h0);
    check("exc_red", {31'b0, red32}, 32'h1); check("exc_pc8", {24'b0, pc8}, 32'h80);
    clear_req(); stall_i = 1'b0;
    step();

    // Wrap at the top of the address space.
    jmp_i = 1'b1; jmp_target_i = 32'hFFFF_FFFC;
    step(); check("wrap_pre32", pc32, 32'hFFFF_FFFC); check("wrap_pre8", {24'b0, pc8}, 32'hFC);
    check("wrap_inc32", pc_inc32, 32'h0);
    jmp_i = 1'b0;
    step(); check("wrap32", pc32, 32'h0); check("wrap8", {24'b0, pc8}, 32'h0);
    check("wrap_red", {31'b0, red32}, 32'h0);

    // Asynchronous reset while a redirect is pending.
    stall_i = 1'b1; jmp_i = 1'b1; jmp_target_i = 32'h300;
    step(); jmp_i = 1'b0;
    check("pre_rst_pend", {31'b0, pend32}, 32'h1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_pc",   pc32,            32'h0);
    check("async_rst_pend", {31'b0, pend32}, 32'h0);
    check("async_rst_pc8",  {24'b0, pc8},    32'h0);
    stall_i = 1'b0;
    step(); rst = 1'b0;
    step(); check("post_rst_pc", pc32, 32'h4); check("post_rst_red", {31'b0, red32}, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      stall_i      = ($urandom_range(0, 99) < 35);
      br_taken_i   = ($urandom_range(0, 99) < 12);
      jmp_i        = ($urandom_range(0, 99) < 12);
      exc_i        = ($urandom_range(0, 99) < 3);
      br_target_i  = $urandom;
      jmp_target_i = $urandom;
      if ($urandom_range(0, 99) < 15) jmp_target_i = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
      rst          = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    clear_req();
    stall_i = 1'b0;
    step();
    step();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
